// File: rtl/neuron_sweep_engine.sv
// neuron_sweep_engine
//
// Sequential neuron sweep for a neuromorphic core. On an accepted tick the axon spike vector is
// latched and every neuron record in the external SRAM is visited in order: read, integrate
// (V + popcount(connections & axons) * A - leak), saturate, threshold, write back, and emit a
// spike when the neuron fires. Outgoing spikes use a valid/ready handshake that stalls the sweep.
//
// Optional feature (compile-time macro):
//   NEURON_LEAK_EN  defined   -> leak = B (sign-extended), subtracted every sweep
//                   undefined -> leak = 0, B is ignored and written back unchanged
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   tick                start a sweep (dropped and flagged with tick_overrun when busy)
//   axon_spikes         spike vector, latched on an accepted tick
//   sram_addr           neuron index for both reads and writes
//   sram_rd_en          read strobe, sram_rdata valid on the following cycle
//   sram_rdata          record {A, B, C, vthresh, connections, membrane_potential}, MSB..LSB
//   sram_wr_en          write strobe
//   sram_wdata          record to write
//   spike_valid         outgoing spike, held until spike_ready
//   spike_idx           index of the spiking neuron
//   spike_ready         downstream accepts the spike
//   busy                sweep active (every state but idle)
//   done                1-cycle pulse at the end of a sweep
//   tick_overrun        1-cycle pulse when a tick is dropped
//
// Record layout (REC_W = 5*V_PRECISION + AXON_COUNT bits):
//   A | B | C | vthresh | connections[AXON_COUNT] | membrane_potential

module neuron_sweep_engine #(
  parameter int unsigned N_COUNT     = 256,
  parameter int unsigned AXON_COUNT  = 256,
  parameter int unsigned V_PRECISION = 9,
  // A single-neuron core still needs a 1-bit address port
  localparam int unsigned ADDR_W = (N_COUNT > 1) ? $clog2(N_COUNT) : 1,
  localparam int unsigned REC_W  = 5 * V_PRECISION + AXON_COUNT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick,
  input  logic [AXON_COUNT-1:0] axon_spikes,
  output logic [ADDR_W-1:0]     sram_addr,
  output logic                  sram_rd_en,
  input  logic [REC_W-1:0]      sram_rdata,
  output logic                  sram_wr_en,
  output logic [REC_W-1:0]      sram_wdata,
  output logic                  spike_valid,
  output logic [ADDR_W-1:0]     spike_idx,
  input  logic                  spike_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  tick_overrun
);

  localparam int unsigned POP_W    = $clog2(AXON_COUNT + 1);
  localparam int unsigned SUM_W    = V_PRECISION + POP_W + 2;
  localparam int unsigned CONN_LSB = V_PRECISION;
  localparam int unsigned VTH_LSB  = V_PRECISION + AXON_COUNT;
  localparam int unsigned C_LSB    = 2 * V_PRECISION + AXON_COUNT;
  localparam int unsigned A_LSB    = 4 * V_PRECISION + AXON_COUNT;

  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((2 ** (V_PRECISION - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_COUNT - 1);

  typedef enum logic [2:0] {StIdle, StRd, StUpd, StWr, StEmit, StDone} state_e;

  state_e                  state_q;
  logic [ADDR_W-1:0]       idx_q;
  logic [AXON_COUNT-1:0]   axons_q;
  logic                    fire_q;
  // Low for the first edge after reset release so a coincident tick is ignored
  logic                    armed_q;

  logic [ADDR_W-1:0]       sram_addr_q;
  logic                    sram_rd_en_q;
  logic                    sram_wr_en_q;
  logic [REC_W-1:0]        sram_wdata_q;
  logic                    spike_valid_q;
  logic [ADDR_W-1:0]       spike_idx_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    tick_overrun_q;

  // ---------------------------------------------------------------------------------------------
  // Integrate / saturate / threshold datapath, evaluated on sram_rdata during StUpd
  // ---------------------------------------------------------------------------------------------
  logic signed [V_PRECISION-1:0] f_a, f_c, f_vth, f_v;
  logic [AXON_COUNT-1:0]         f_conn;
  logic [AXON_COUNT-1:0]         active;
  logic [POP_W-1:0]              pop;
  logic signed [SUM_W-1:0]       v_ext, a_ext, pop_ext, prod, leak_ext, sum;
  logic signed [V_PRECISION-1:0] sat_v, v_new;
  logic                          fire;

  assign f_a    = sram_rdata[A_LSB +: V_PRECISION];
  assign f_c    = sram_rdata[C_LSB +: V_PRECISION];
  assign f_vth  = sram_rdata[VTH_LSB +: V_PRECISION];
  assign f_conn = sram_rdata[CONN_LSB +: AXON_COUNT];
  assign f_v    = sram_rdata[V_PRECISION-1:0];
  assign active = f_conn & axons_q;

`ifdef NEURON_LEAK_EN
  localparam int unsigned B_LSB = 3 * V_PRECISION + AXON_COUNT;
  logic signed [V_PRECISION-1:0] f_b;
  assign f_b      = sram_rdata[B_LSB +: V_PRECISION];
  assign leak_ext = {{(SUM_W - V_PRECISION){f_b[V_PRECISION-1]}}, f_b};
`else
  assign leak_ext = '0;
`endif

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < AXON_COUNT; i++) begin
      pop = pop + POP_W'(active[i]);
    end
  end

  // Everything is widened to SUM_W so the sum cannot wrap before saturation
  assign v_ext   = {{(SUM_W - V_PRECISION){f_v[V_PRECISION-1]}}, f_v};
  assign a_ext   = {{(SUM_W - V_PRECISION){f_a[V_PRECISION-1]}}, f_a};
  assign pop_ext = {{(SUM_W - POP_W){1'b0}}, pop};
  assign prod    = pop_ext * a_ext;
  assign sum     = v_ext + prod - leak_ext;

  always_comb begin
    if (sum > SAT_MAX) begin
      sat_v = SAT_MAX[V_PRECISION-1:0];
    end else if (sum < SAT_MIN) begin
      sat_v = SAT_MIN[V_PRECISION-1:0];
    end else begin
      sat_v = sum[V_PRECISION-1:0];
    end
  end

  assign fire  = (sat_v >= f_vth);
  assign v_new = fire ? f_c : sat_v;

  // ---------------------------------------------------------------------------------------------
  // Sweep FSM with registered outputs
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      idx_q          <= '0;
      axons_q        <= '0;
      fire_q         <= 1'b0;
      armed_q        <= 1'b0;
      sram_addr_q    <= '0;
      sram_rd_en_q   <= 1'b0;
      sram_wr_en_q   <= 1'b0;
      sram_wdata_q   <= '0;
      spike_valid_q  <= 1'b0;
      spike_idx_q    <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      tick_overrun_q <= 1'b0;
    end else begin
      armed_q        <= 1'b1;
      sram_rd_en_q   <= 1'b0;
      sram_wr_en_q   <= 1'b0;
      done_q         <= 1'b0;
      tick_overrun_q <= tick && (state_q != StIdle);

      unique case (state_q)
        StIdle: begin
          if (tick && armed_q) begin
            axons_q      <= axon_spikes;
            idx_q        <= '0;
            sram_addr_q  <= '0;
            sram_rd_en_q <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= StRd;
          end
        end
        StRd: begin
          state_q <= StUpd;
        end
        StUpd: begin
          sram_wdata_q <= {sram_rdata[REC_W-1:V_PRECISION], v_new};
          fire_q       <= fire;
          sram_wr_en_q <= 1'b1;
          state_q      <= StWr;
        end
        StWr: begin
          if (fire_q) begin
            spike_valid_q <= 1'b1;
            spike_idx_q   <= idx_q;
            state_q       <= StEmit;
          end else if (idx_q == LAST_IDX) begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            idx_q        <= idx_q + ADDR_W'(1);
            sram_addr_q  <= idx_q + ADDR_W'(1);
            sram_rd_en_q <= 1'b1;
            state_q      <= StRd;
          end
        end
        StEmit: begin
          if (spike_ready) begin
            spike_valid_q <= 1'b0;
            if (idx_q == LAST_IDX) begin
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              idx_q        <= idx_q + ADDR_W'(1);
              sram_addr_q  <= idx_q + ADDR_W'(1);
              sram_rd_en_q <= 1'b1;
              state_q      <= StRd;
            end
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign sram_addr    = sram_addr_q;
  assign sram_rd_en   = sram_rd_en_q;
  assign sram_wr_en   = sram_wr_en_q;
  assign sram_wdata   = sram_wdata_q;
  assign spike_valid  = spike_valid_q;
  assign spike_idx    = spike_idx_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign tick_overrun = tick_overrun_q;

endmodule

// File: tb/tb_neuron_sweep_engine.sv
module tb_neuron_sweep_engine;

  localparam int N     = 4;
  localparam int AX    = 8;
  localparam int VP    = 9;
  localparam int REC_W = 5 * VP + AX;
  localparam int AW    = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             tick = 1'b0;
  logic [AX-1:0]    axon_spikes = '0;
  logic [AW-1:0]    sram_addr;
  logic             sram_rd_en;
  logic [REC_W-1:0] sram_rdata = '0;
  logic             sram_wr_en;
  logic [REC_W-1:0] sram_wdata;
  logic             spike_valid;
  logic [AW-1:0]    spike_idx;
  logic             spike_ready = 1'b0;
  logic             busy, done, tick_overrun;

  always #5 clk = ~clk;

  neuron_sweep_engine #(.N_COUNT(N), .AXON_COUNT(AX), .V_PRECISION(VP)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .axon_spikes(axon_spikes),
    .sram_addr(sram_addr), .sram_rd_en(sram_rd_en), .sram_rdata(sram_rdata),
    .sram_wr_en(sram_wr_en), .sram_wdata(sram_wdata),
    .spike_valid(spike_valid), .spike_idx(spike_idx), .spike_ready(spike_ready),
    .busy(busy), .done(done), .tick_overrun(tick_overrun)
  );

  // SRAM model with a bench-side load port
  logic [REC_W-1:0] sram_mem [N];
  logic             load_en = 1'b0;
  int               load_addr = 0;
  logic [REC_W-1:0] load_data = '0;

  always @(posedge clk) begin
    if (sram_rd_en) sram_rdata <= sram_mem[sram_addr];
    if (load_en) sram_mem[load_addr] <= load_data;
    else if (sram_wr_en) sram_mem[sram_addr] <= sram_wdata;
  end

  // 0: ready high, 1: random, 2: held low, 3: forced high
  int ready_mode = 0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1:       spike_ready = 1'($urandom_range(0, 1));
      2:       spike_ready = 1'b0;
      default: spike_ready = 1'b1;
    endcase
  end

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: actual=event required=no event", name);
  endtask

  // Reference model: plain integer arithmetic on the record fields
  logic [REC_W-1:0] ref_mem [N];

  typedef struct packed {
    logic [AW-1:0]    addr;
    logic [REC_W-1:0] data;
  } wr_t;
  wr_t wq[$];
  int  sq[$];

  function automatic logic [REC_W-1:0] mk(input int a, input int b, input int c, input int vth,
                                          input logic [AX-1:0] conn, input int v);
    return {a[VP-1:0], b[VP-1:0], c[VP-1:0], vth[VP-1:0], conn, v[VP-1:0]};
  endfunction

  function automatic logic [REC_W-1:0] ref_neuron(input logic [REC_W-1:0] rec,
                                                  input logic [AX-1:0] ax, output bit fire);
    int a, b, c, vth, v, pop, sum, leak, hi, lo;
    a    = int'($signed(rec[4*VP+AX +: VP]));
    b    = int'($signed(rec[3*VP+AX +: VP]));
    c    = int'($signed(rec[2*VP+AX +: VP]));
    vth  = int'($signed(rec[VP+AX +: VP]));
    v    = int'($signed(rec[VP-1:0]));
    pop  = $countones(rec[VP +: AX] & ax);
`ifdef NEURON_LEAK_EN
    leak = b;
`else
    leak = 0;
`endif
    hi   = (1 << (VP - 1)) - 1;
    lo   = -(1 << (VP - 1));
    sum  = v + pop * a - leak;
    if (sum > hi) sum = hi;
    if (sum < lo) sum = lo;
    fire = (sum >= vth);
    if (fire) sum = c;
    return {rec[REC_W-1:VP], sum[VP-1:0]};
  endfunction

  task automatic plan_sweep(input logic [AX-1:0] ax);
    bit f;
    logic [REC_W-1:0] e;
    for (int i = 0; i < N; i++) begin
      e = ref_neuron(ref_mem[i], ax, f);
      wq.push_back('{addr: AW'(i), data: e});
      ref_mem[i] = e;
      if (f) sq.push_back(i);
    end
  endtask

  task automatic load(input int a, input logic [REC_W-1:0] d);
    @(posedge clk);
    #1 load_addr = a; load_data = d; load_en = 1'b1;
    @(posedge clk);
    #1 load_en = 1'b0;
    ref_mem[a] = d;
  endtask

  function automatic logic [REC_W-1:0] rand_rec();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[REC_W-1:0];
  endfunction

  task automatic start_sweep(input logic [AX-1:0] ax);
    plan_sweep(ax);
    @(posedge clk);
    #1 axon_spikes = ax; tick = 1'b1;
    @(posedge clk);
    #1 tick = 1'b0; axon_spikes = AX'($urandom);
  endtask

  task automatic wait_done(output int cyc);
    bit seen = 0;
    cyc = 0;
    for (int k = 1; k <= 3000; k++) begin
      @(negedge clk);
      if (done) begin
        cyc = k;
        seen = 1;
        break;
      end
    end
    if (!seen) fail_now("done_timeout");
  endtask

  // Monitor / scoreboard
  int  wr_cnt = 0;
  int  done_cnt = 0;
  int  ovr_cnt = 0;
  wr_t mon_e;

  always @(negedge clk) begin
    if (rst_n) begin
      if (sram_rd_en || sram_wr_en) check_eq("rd_wr_exclusive", 64'(sram_rd_en & sram_wr_en), 0);
      if (sram_wr_en) begin
        wr_cnt++;
        if (wq.size() == 0) fail_now("unexpected_write");
        else begin
          mon_e = wq.pop_front();
          check_eq("wr_addr", 64'(sram_addr), 64'(mon_e.addr));
          check_eq("wr_data", 64'(sram_wdata), 64'(mon_e.data));
        end
      end
      if (spike_valid && spike_ready) begin
        if (sq.size() == 0) fail_now("unexpected_spike");
        else check_eq("spike_idx", 64'(spike_idx), 64'(sq.pop_front()));
      end
      if (done) done_cnt++;
      if (tick_overrun) ovr_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int cyc, sweeps, ov0, wr0;
    bit seen;
    logic [AX-1:0] ax;
    logic [REC_W-1:0] saved [N];
    sweeps = 0;

    #1 rst_n = 1'b0;
    #1;
    check_eq("reset_ctl", 64'({busy, done, tick_overrun, sram_rd_en, sram_wr_en, spike_valid}), 0);
    check_eq("reset_addr_idx", 64'({sram_addr, spike_idx}), 0);
    check_eq("reset_wdata", 64'(sram_wdata), 0);

    // Sweep 1: sub-threshold neuron 0, nothing fires
    load(0, mk(3, 1, 0, 20, 8'h0F, 0));
    for (int i = 1; i < N; i++) load(i, mk(1, 0, 0, 100, 8'h00, 0));
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    ready_mode = 0;
    start_sweep(8'h05);
    wait_done(cyc);
    sweeps++;
    check_eq("latency_no_fire", 64'(cyc), 64'(3 * N + 1));
    @(negedge clk);
    check_eq("idle_after_done", 64'({busy, done}), 0);
`ifdef NEURON_LEAK_EN
    check_eq("n0_v_subthreshold", 64'(sram_mem[0][VP-1:0]), 64'(5));
`else
    check_eq("n0_v_subthreshold", 64'(sram_mem[0][VP-1:0]), 64'(6));
`endif

    // Sweep 2: neuron 1 fires, spike_ready held low for 10 cycles
    load(1, mk(10, 0, -4, 15, 8'hFF, 10));
    ready_mode = 2;
    start_sweep(8'h01);
    seen = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (spike_valid) begin seen = 1; break; end
    end
    if (!seen) fail_now("spike_timeout");
    check_eq("bp_spike_idx", 64'(spike_idx), 1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check_eq("bp_hold", 64'({spike_valid, sram_rd_en, sram_wr_en}), 64'(3'b100));
    end
    ready_mode = 3;
    @(negedge clk);
    @(negedge clk);
    check_eq("bp_resume", 64'({sram_rd_en, spike_valid, sram_addr}), 64'({1'b1, 1'b0, 2'd2}));
    ready_mode = 0;
    wait_done(cyc);
    sweeps++;
    check_eq("n1_v_fired", 64'(sram_mem[1][VP-1:0]), 64'(9'h1FC));

    // Sweep 3: positive and negative saturation
    load(2, mk(-256, 0, 5, 0, 8'hFF, -200));
    load(3, mk(255, 0, 7, 255, 8'hFF, 200));
    start_sweep(8'hFF);
    wait_done(cyc);
    sweeps++;
    check_eq("n2_v_sat_low", 64'(sram_mem[2][VP-1:0]), 64'(9'h100));
    check_eq("n3_v_sat_fire", 64'(sram_mem[3][VP-1:0]), 64'(7));

    // Sweep 4: tick overrun mid-sweep, latched axons must be unaffected
    ready_mode = 1;
    ov0 = ovr_cnt;
    ax = AX'($urandom);
    start_sweep(ax);
    repeat (4) @(posedge clk);
    #1 tick = 1'b1; axon_spikes = ~ax;
    @(posedge clk);
    #1 tick = 1'b0;
    wait_done(cyc);
    sweeps++;
    check_eq("overrun_pulses", 64'(ovr_cnt - ov0), 1);

    // Randomized sweeps
    for (int s = 0; s < 8; s++) begin
      for (int n = 0; n < N; n++) load(n, rand_rec());
      ready_mode = 1;
      start_sweep(AX'($urandom));
      wait_done(cyc);
      sweeps++;
    end

    // Reset during WR of neuron 2
    ready_mode = 0;
    for (int n = 0; n < N; n++) saved[n] = ref_mem[n];
    start_sweep(AX'($urandom));
    seen = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (sram_rd_en && sram_addr == 2'd2) begin seen = 1; break; end
    end
    if (!seen) fail_now("rd_n2_timeout");
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midreset_ctl", 64'({busy, sram_rd_en, sram_wr_en, spike_valid, done}), 0);
    check_eq("midreset_wdata", 64'(sram_wdata), 0);
    check_eq("midreset_pending", 64'(wq.size()), 2);
    wr0 = wr_cnt;
    ref_mem[2] = saved[2];
    ref_mem[3] = saved[3];
    wq.delete();
    sq.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1; tick = 1'b1; axon_spikes = 8'hFF;
    @(posedge clk);
    #1 tick = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("tick_at_release_ignored", 64'({busy, tick_overrun}), 0);
    check_eq("no_write_after_reset", 64'(wr_cnt - wr0), 0);
    check_eq("n3_untouched", 64'(sram_mem[3]), 64'(saved[3]));

    // Recovery sweep
    start_sweep(AX'($urandom));
    wait_done(cyc);
    sweeps++;

    repeat (2) @(negedge clk);
    check_eq("done_count", 64'(done_cnt), 64'(sweeps));
    check_eq("writes_drained", 64'(wq.size()), 0);
    check_eq("spikes_drained", 64'(sq.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/neuron_sweep_engine.md
NEURON_SWEEP_ENGINE -- requirements
Module: neuron_sweep_engine

Interface
REQ-001 SHALL have parameter N_COUNT, default 256: neurons per core; SRAM depth.
REQ-002 SHALL have parameter AXON_COUNT, default 256: input axons; width of the connections field.
REQ-003 SHALL have parameter V_PRECISION, default 9: signed width of A, B, C, vthresh and membrane_potential.
REQ-004 SHALL have localparams ADDR_W = $clog2(N_COUNT) and REC_W = 5*V_PRECISION + AXON_COUNT.
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port tick, input, 1 bit: starts a sweep of all neurons.
REQ-009 SHALL have port axon_spikes, input, AXON_COUNT bits: spike vector, sampled on an accepted tick.
REQ-010 SHALL have port sram_addr, output, ADDR_W bits: neuron index.
REQ-011 SHALL have port sram_rd_en, output, 1 bit: read strobe; sram_rdata is valid exactly 1 cycle later.
REQ-012 SHALL have port sram_rdata, input, REC_W bits: record {A,B,C,vthresh,connections,membrane_potential}, MSB to LSB.
REQ-013 SHALL have port sram_wr_en, output, 1 bit: write strobe.
REQ-014 SHALL have port sram_wdata, output, REC_W bits: record to write.
REQ-015 SHALL have port spike_valid, output, 1 bit: outgoing spike.
REQ-016 SHALL have port spike_idx, output, ADDR_W bits: index of the spiking neuron.
REQ-017 SHALL have port spike_ready, input, 1 bit: downstream accepts the spike.
REQ-018 SHALL have ports busy, done and tick_overrun, output, 1 bit each: sweep active, 1-cycle end pulse, and 1-cycle pulse when a tick is dropped.

Function
REQ-019 SHALL implement FSM states IDLE, RD, UPD, WR, EMIT and DONE.
REQ-020 SHALL leave IDLE for RD on tick; axon_spikes is latched into an internal register and idx is set to 0.
REQ-021 SHALL in RD assert sram_rd_en for 1 cycle with sram_addr = idx, then go to UPD.
REQ-022 SHALL in UPD compute sum = V + popcount(connections & latched_axons)*A - leak, in signed width V_PRECISION + $clog2(AXON_COUNT+1) + 2.
REQ-023 SHALL in UPD saturate sum to the signed V_PRECISION range [-2^(V_PRECISION-1), 2^(V_PRECISION-1)-1].
REQ-024 SHALL in UPD set fire = (saturated sum >= vthresh), compared signed.
REQ-025 SHALL in UPD set V' = C when fire, else V' = saturated sum.
REQ-026 SHALL in UPD register sram_wdata as the read record with membrane_potential replaced by V'; all other fields are unchanged.
REQ-027 SHALL in WR assert sram_wr_en for 1 cycle with sram_addr = idx, then go to EMIT if fire, else advance.
REQ-028 SHALL in EMIT hold spike_valid = 1 and spike_idx = idx until spike_ready is seen high; the sweep stalls indefinitely meanwhile.
REQ-029 SHALL advance as follows: if idx == N_COUNT-1 go to DONE, else idx+1 and go to RD. Latency is 3 cycles per non-firing neuron and 4 or more per firing neuron.
REQ-030 SHALL in DONE pulse done for 1 cycle, then go to IDLE; busy = 1 in every state except IDLE.
REQ-031 SHALL, when tick arrives while busy (including in DONE), ignore it, pulse tick_overrun, and leave the latched axons unchanged.
REQ-032 SHALL never assert sram_rd_en and sram_wr_en in the same cycle.
REQ-033 SHALL when N_COUNT == 1 perform a one-neuron sweep with sram_addr = 0.

Reset
REQ-034 SHALL on rst_n low immediately (asynchronously) force the FSM to IDLE, idx = 0, latched axons = 0, and all outputs to 0, including sram_wdata.
REQ-035 SHALL on a reset mid-sweep abort the sweep with no further SRAM writes; the partially updated SRAM is not repaired.
REQ-036 SHALL ignore a tick that is coincident with the rst_n deassertion edge.

Configuration
REQ-037 SHALL with macro NEURON_LEAK_EN defined use leak = B, sign-extended, every sweep.
REQ-038 SHALL with NEURON_LEAK_EN undefined use leak = 0, ignore B, and write B back unchanged.

Verification (N_COUNT=4, AXON_COUNT=8, V_PRECISION=9, NEURON_LEAK_EN defined)
REQ-039 SHALL cover a sub-threshold neuron: neuron0 A=3, B=1, V=0, vthresh=20, connections=8'h0F, axons=8'h05 -> written V=5, no spike, done after 12 cycles when no neuron fires.
REQ-040 SHALL cover a firing neuron: neuron1 A=10, B=0, C=-4, vthresh=15, V=10, connections=8'hFF, axons=8'h01 -> V=-4 written, spike_idx=1.
REQ-041 SHALL cover saturation: A=255, V=200, 8 active synapses, vthresh=255 -> sum clamps to 255 and the neuron fires.
REQ-042 SHALL cover backpressure: spike_ready held low for 10 cycles on a firing neuron -> spike_valid is held, no SRAM access, and the sweep resumes the cycle after ready.
REQ-043 SHALL cover a tick overrun and a reset mid-sweep: tick at sweep cycle 5 -> tick_overrun is pulsed once and the axons are unchanged; rst_n low during WR of neuron2 -> busy=0 and no write to neuron3.
